// File: rtl/chrisruk_frame_arbiter.sv
// Round-robin frame arbiter sharing one strip serializer between two requesters.
// One-cycle START pulse, BUSY until ser_done or timeout, then a fixed idle gap.
module chrisruk_frame_arbiter #(
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 8191
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       ser_done,
  output logic       ser_start,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  localparam logic [12:0] TIMEOUT_C = 13'(TIMEOUT);
  localparam logic [12:0] GAP_END   = 13'(GAP_CYCLES - 1);

  state_t      state;
  logic [12:0] cnt;
  logic        last;
  logic        pick;

  // pick = 1 selects requester 1; on contention the one not served last wins
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ~last;
  end

  assign busy = (state == START) || (state == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      ser_start   <= 1'b0;
      frame_cnt   <= 8'd0;
      timeout_err <= 1'b0;
      cnt         <= 13'd0;
      last        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state     <= START;
            gnt       <= pick ? 2'b10 : 2'b01;
            last      <= pick;
            ser_start <= 1'b1;
          end
        end
        START: begin
          ser_start <= 1'b0;
          state     <= BUSY;
          cnt       <= 13'd1;
        end
        BUSY: begin
          // ser_done wins over a coinciding timeout
          if (ser_done) begin
            state     <= GAP;
            gnt       <= 2'b00;
            frame_cnt <= frame_cnt + 8'd1;
            cnt       <= 13'd0;
          end else if (cnt == TIMEOUT_C) begin
            state       <= GAP;
            gnt         <= 2'b00;
            timeout_err <= 1'b1;
            cnt         <= 13'd0;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            state <= IDLE;
            cnt   <= 13'd0;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 2'b00;
          ser_start <= 1'b0;
          cnt       <= 13'd0;
        end
      endcase
    end
  end

endmodule
